rnn_seq_loader: RTL
===================

RNN_SEQ_LOADER -- requirements
Module: rnn_seq_loader

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of one sequence sample.
REQ-002 Parameter SEQUENCE_LENGTH, default 32: number of samples per frame issued to the accelerator.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-004 s_valid  in  1  upstream sample valid.
REQ-005 s_data  in  DATA_WIDTH  upstream sample.
REQ-006 s_last  in  1  marks the final sample of an upstream sequence.
REQ-007 s_ready  out  1  block accepts a sample this cycle.
REQ-008 seq_data  out  SEQUENCE_LENGTH*DATA_WIDTH  frame to accelerator; element i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 seq_start  out  1  one-cycle pulse: frame valid, accelerator begins.
REQ-010 seq_done  in  1  accelerator finished the frame.
REQ-011 frame_len  out  $clog2(SEQUENCE_LENGTH+1)  real (non-pad) samples in the current frame.
REQ-012 short_frame / trunc_frame  out  1 each  frame was zero-padded / frame was truncated.

Function
REQ-013 Sample transfer SHALL occur on the rising edge of clk when s_valid and s_ready are both 1.
REQ-014 The FSM SHALL have the states FILL, PAD, ISSUE and BUSY.
REQ-015 In FILL, s_ready SHALL be 1; each accepted sample SHALL be written to element wr_idx, and wr_idx SHALL increment.
REQ-016 In FILL, acceptance with wr_idx==SEQUENCE_LENGTH-1 SHALL cause a transition to ISSUE; acceptance with s_last and wr_idx<SEQUENCE_LENGTH-1 SHALL cause a transition to PAD.
REQ-017 In PAD, s_ready SHALL be 0; one zero SHALL be written per cycle at indices k..SEQUENCE_LENGTH-1, where k is the number of accepted samples; the FSM SHALL then transition to ISSUE.
REQ-018 In ISSUE, seq_start SHALL be 1 for exactly one cycle, then the FSM SHALL transition to BUSY.
REQ-019 In BUSY, the FSM SHALL wait for seq_done, then return to FILL with wr_idx=0.
REQ-020 seq_done SHALL be ignored outside BUSY, including in the ISSUE cycle.
REQ-021 Latency: seq_start SHALL assert 1 cycle after the accept of the last sample of a full frame, and (SEQUENCE_LENGTH-k)+1 cycles after it for a k-sample frame.
REQ-022 seq_data, frame_len, short_frame and trunc_frame SHALL be stable from the seq_start cycle until the cycle after seq_done is sampled in BUSY.
REQ-023 If the SEQUENCE_LENGTH-th sample is accepted without s_last, trunc_frame SHALL be set and a discard_pending flag SHALL be set.
REQ-024 While discard_pending=1, s_ready SHALL be 1 in BUSY and in FILL, and accepted samples SHALL be dropped, not written, and not counted.
REQ-025 Acceptance of a sample with s_last while discard_pending=1 SHALL clear discard_pending.
REQ-026 A sample carrying both s_last and the SEQUENCE_LENGTH-th position SHALL give a full frame with no truncation.
REQ-027 In all states other than those named in REQ-015 and REQ-024, s_ready SHALL be 0.
REQ-028 frame_len, short_frame and trunc_frame SHALL be updated on entry to ISSUE.

Reset
REQ-029 While rst_n=0 (asynchronous), the FSM SHALL be in FILL, with wr_idx=0 and discard_pending=0.
REQ-030 While rst_n=0, all buffer elements, seq_data, frame_len, short_frame, trunc_frame and seq_start SHALL be 0, and s_ready SHALL be 0.
REQ-031 s_ready SHALL rise on the first clk edge after rst_n is released.
REQ-032 A reset mid-frame SHALL discard the partial frame; no seq_start SHALL issue for it.

Configuration
REQ-033 The macro RNN_SEQ_LOADER_STATS_EN SHALL control the statistics feature.
REQ-034 With RNN_SEQ_LOADER_STATS_EN defined: frame_cnt (out, 16) SHALL increment on each seq_start, and trunc_cnt (out, 16) SHALL increment on each truncated frame; both SHALL wrap at 0xFFFF->0 and reset to 0.
REQ-035 Without RNN_SEQ_LOADER_STATS_EN, frame_cnt, trunc_cnt and their logic SHALL be absent.

Verification
REQ-036 Full frame: 32 samples 0x0001..0x0020 with s_last on the 32nd -> seq_start 1 cycle after the last accept, element31=0x0020, frame_len=32, both flags 0.
REQ-037 Short frame: 5 samples 0xA000..0xA004 with s_last -> 27 PAD cycles, seq_start 28 cycles after the last accept, elements5..31=0, frame_len=5, short_frame=1.
REQ-038 Truncation: 40 samples, s_last on the 40th -> frame holds samples 1..32, trunc_frame=1, samples 33..40 accepted and dropped, and the next frame starts clean at wr_idx=0.
REQ-039 Busy hold: s_valid=1 continuously during BUSY (no discard) -> s_ready=0, seq_data unchanged until seq_done; seq_done pulsed in the ISSUE cycle or in FILL -> ignored.
REQ-040 Reset mid-fill: 10 samples, then rst_n=0 for 2 cycles -> all outputs 0, no seq_start; a following 32-sample frame is correct.
REQ-041 Stats (macro defined): 3 frames, 1 of them truncated -> frame_cnt=3, trunc_cnt=1.

Source files
------------

// File: rtl/rnn_seq_loader_if.sv
// rnn_seq_loader_if: bundles the upstream sample stream and the accelerator frame port of rnn_seq_loader.
//   s_valid/s_data/s_last/s_ready : upstream sample handshake
//   seq_data/seq_start/seq_done   : frame to accelerator, start pulse, completion
//   frame_len/short_frame/trunc_frame : frame descriptors
//   frame_cnt/trunc_cnt           : statistics, present only with RNN_SEQ_LOADER_STATS_EN
// master = sample producer / accelerator side, slave = the loader.
interface rnn_seq_loader_if #(
    parameter int DATA_WIDTH      = 16,
    parameter int SEQUENCE_LENGTH = 32
);
    localparam int LW = $clog2(SEQUENCE_LENGTH + 1);
    logic                                s_valid;
    logic [DATA_WIDTH-1:0]               s_data;
    logic                                s_last;
    logic                                s_ready;
    logic [SEQUENCE_LENGTH*DATA_WIDTH-1:0] seq_data;
    logic                                seq_start;
    logic                                seq_done;
    logic [LW-1:0]                       frame_len;
    logic                                short_frame;
    logic                                trunc_frame;
`ifdef RNN_SEQ_LOADER_STATS_EN
    logic [15:0]                         frame_cnt;
    logic [15:0]                         trunc_cnt;
    modport master (output s_valid, s_data, s_last, seq_done,
                    input  s_ready, seq_data, seq_start, frame_len, short_frame, trunc_frame, frame_cnt, trunc_cnt);
    modport slave  (input  s_valid, s_data, s_last, seq_done,
                    output s_ready, seq_data, seq_start, frame_len, short_frame, trunc_frame, frame_cnt, trunc_cnt);
`else
    modport master (output s_valid, s_data, s_last, seq_done,
                    input  s_ready, seq_data, seq_start, frame_len, short_frame, trunc_frame);
    modport slave  (input  s_valid, s_data, s_last, seq_done,
                    output s_ready, seq_data, seq_start, frame_len, short_frame, trunc_frame);
`endif
endinterface

// File: rtl/rnn_seq_loader.sv
// rnn_seq_loader: collects upstream samples into a fixed-length frame (zero-padding short sequences,
// truncating long ones) and hands it to an RNN accelerator with a one-cycle start pulse.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus (slave): sample handshake in, frame/start/descriptors out, seq_done in
// Optional: define RNN_SEQ_LOADER_STATS_EN to add frame_cnt / trunc_cnt counters.
module rnn_seq_loader #(
    parameter int DATA_WIDTH      = 16,
    parameter int SEQUENCE_LENGTH = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    rnn_seq_loader_if.slave bus
);
    localparam int LW = $clog2(SEQUENCE_LENGTH + 1);
    localparam logic [LW-1:0] LAST = LW'(SEQUENCE_LENGTH - 1);
    localparam logic [LW-1:0] FULL = LW'(SEQUENCE_LENGTH);

    typedef enum logic [1:0] {FILL, PAD, ISSUE, BUSY} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         wr_idx_q, wr_idx_d, k_q, k_d, frame_len_q, frame_len_d;
    logic                  discard_q, discard_d, s_ready_q, s_ready_d, seq_start_q, seq_start_d;
    logic                  short_q, short_d, trunc_q, trunc_d;
    logic                  acc, wr_en;
    logic [DATA_WIDTH-1:0] wr_val;

    assign acc = bus.s_valid & s_ready_q;

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        k_d         = k_q;
        discard_d   = discard_q;
        frame_len_d = frame_len_q;
        short_d     = short_q;
        trunc_d     = trunc_q;
        wr_en       = 1'b0;
        wr_val      = bus.s_data;
        case (state_q)
            FILL: if (acc) begin
                if (discard_q) begin
                    discard_d = ~bus.s_last;
                end else begin
                    wr_en    = 1'b1;
                    wr_idx_d = wr_idx_q + LW'(1);
                    if (wr_idx_q == LAST) begin
                        // A last-position sample without s_last means the sequence overflows the frame.
                        state_d     = ISSUE;
                        frame_len_d = FULL;
                        short_d     = 1'b0;
                        trunc_d     = ~bus.s_last;
                        discard_d   = ~bus.s_last;
                    end else if (bus.s_last) begin
                        state_d = PAD;
                        k_d     = wr_idx_q + LW'(1);
                    end
                end
            end
            PAD: begin
                wr_en    = 1'b1;
                wr_val   = '0;
                wr_idx_d = wr_idx_q + LW'(1);
                if (wr_idx_q == LAST) begin
                    state_d     = ISSUE;
                    frame_len_d = k_q;
                    short_d     = 1'b1;
                    trunc_d     = 1'b0;
                end
            end
            ISSUE: state_d = BUSY;
            BUSY: begin
                if (acc && bus.s_last) discard_d = 1'b0;
                if (bus.seq_done) begin
                    state_d  = FILL;
                    wr_idx_d = '0;
                end
            end
            default: state_d = FILL;
        endcase
        seq_start_d = state_d == ISSUE;
        // Registered ready: follows the next state so it is valid in the cycle it applies to.
        s_ready_d   = state_d == FILL || (state_d == BUSY && discard_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            wr_idx_q    <= '0;
            k_q         <= '0;
            discard_q   <= 1'b0;
            frame_len_q <= '0;
            short_q     <= 1'b0;
            trunc_q     <= 1'b0;
            s_ready_q   <= 1'b0;
            seq_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            k_q         <= k_d;
            discard_q   <= discard_d;
            frame_len_q <= frame_len_d;
            short_q     <= short_d;
            trunc_q     <= trunc_d;
            s_ready_q   <= s_ready_d;
            seq_start_q <= seq_start_d;
        end
    end

    for (genvar i = 0; i < SEQUENCE_LENGTH; i++) begin : g_buf
        logic [DATA_WIDTH-1:0] buf_q, buf_d;
        assign buf_d = (wr_en && wr_idx_q == LW'(i)) ? wr_val : buf_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) buf_q <= '0;
            else        buf_q <= buf_d;
        end
        assign bus.seq_data[i*DATA_WIDTH +: DATA_WIDTH] = buf_q;
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.seq_start   = seq_start_q;
    assign bus.frame_len   = frame_len_q;
    assign bus.short_frame = short_q;
    assign bus.trunc_frame = trunc_q;

`ifdef RNN_SEQ_LOADER_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d, trunc_cnt_q, trunc_cnt_d;
    assign frame_cnt_d = frame_cnt_q + 16'(seq_start_d);
    assign trunc_cnt_d = trunc_cnt_q + 16'(seq_start_d & trunc_d);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            trunc_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.trunc_cnt = trunc_cnt_q;
`endif
endmodule
